// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_pkg.sv
// Shared helpers for the clocked delay-line cell family: select-width derivation,
// select clamping and the per-edge line operation.
package gf180mcu_fd_sc_mcu7t5v0__dlyline_pkg;

    // Operation applied to the whole line on a rising clock edge.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_SHIFT = 2'd1,
        OP_FLUSH = 2'd2
    } dly_op_e;

    // Bits needed to encode a delay of 0..depth cycles.
    function automatic int unsigned dly_sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Effective delay: any request beyond the physical depth saturates at depth.
    function automatic int unsigned dly_sel_clamp(input int unsigned sel,
                                                  input int unsigned depth);
        return (sel > depth) ? depth : sel;
    endfunction

    // Flush wins over enable; a flushed edge never captures the input.
    function automatic dly_op_e dly_decode_op(input logic flush, input logic en);
        if (flush) return OP_FLUSH;
        if (en)    return OP_SHIFT;
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_stage.sv
// One WIDTH-bit storage stage of the delay line: async reset and sync flush to
// RST_VAL, load on enable.
module gf180mcu_fd_sc_mcu7t5v0__dlyline_stage #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // NOTE: every stage is reset, not just the fill counter, because Z exposes
    // stage contents directly and must read RST_VAL straight out of reset.
    // NOTE: non-blocking assignments keep all stages sampling the pre-edge values,
    // which is what makes the chain shift by exactly one position per edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q <= RST_VAL;
        end else if (FLUSH) begin
            Q <= RST_VAL;
        end else if (EN) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_func.sv
// Clocked delay line: WIDTH-bit bus delayed by a run-time selectable 0..DEPTH enabled
// edges, with a fill counter that marks Z as a genuine sample.
module gf180mcu_fd_sc_mcu7t5v0__dlyline_func
    import gf180mcu_fd_sc_mcu7t5v0__dlyline_pkg::*;
#(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int unsigned     SELW    = dly_sel_width(DEPTH)
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] I,
    input  logic [SELW-1:0]  SEL,
    output logic [WIDTH-1:0] Z,
    output logic             ZV
);

    localparam logic [SELW-1:0] FULL = SELW'(DEPTH);

    dly_op_e         op;
    logic [SELW-1:0] fcnt;
    logic [SELW-1:0] sel_eff;
    logic [WIDTH-1:0] stage_q [DEPTH];

    assign op      = dly_decode_op(FLUSH, EN);
    assign sel_eff = SELW'(dly_sel_clamp(32'(SEL), DEPTH));

    // Stage k holds the sample captured k+1 enabled edges ago.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            gf180mcu_fd_sc_mcu7t5v0__dlyline_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .CLK   (CLK),
                .RST   (RST),
                .EN    (EN),
                .FLUSH (FLUSH),
                .D     (I),
                .Q     (stage_q[k])
            );
        end else begin : g_tail
            gf180mcu_fd_sc_mcu7t5v0__dlyline_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .CLK   (CLK),
                .RST   (RST),
                .EN    (EN),
                .FLUSH (FLUSH),
                .D     (stage_q[k-1]),
                .Q     (stage_q[k])
            );
        end
    end

    // Fill count saturates at DEPTH so a full line stays valid indefinitely.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fcnt <= '0;
        end else begin
            case (op)
                OP_FLUSH: fcnt <= '0;
                OP_SHIFT: if (fcnt != FULL) fcnt <= fcnt + SELW'(1);
                default:  ;
            endcase
        end
    end

    // NOTE: Z and ZV get their bypass values first so every path through this
    // block assigns them and no latch is inferred.
    always_comb begin
        Z  = I;
        ZV = 1'b1;
        if (sel_eff != '0) begin
            Z = RST_VAL;
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (sel_eff == SELW'(k + 1)) Z = stage_q[k];
            end
            ZV = (fcnt >= sel_eff);
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dlyline_func.sv
// Scoreboard bench for the delay line: the driver pushes model expectations, a
// monitor pops and compares them at the falling edge.
module tb_gf180mcu_fd_sc_mcu7t5v0__dlyline_func;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SELW  = 4;
    localparam logic [7:0]  RV    = 8'h3C;

    typedef struct {
        string      tag;
        logic [7:0] z;
        logic       zv;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            EN = 1'b0;
    logic            FLUSH = 1'b0;
    logic [7:0]      I = '0;
    logic [SELW-1:0] SEL = '0;
    logic [7:0]      Z;
    logic            ZV;

    gf180mcu_fd_sc_mcu7t5v0__dlyline_func #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RV)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .FLUSH (FLUSH),
        .I     (I),
        .SEL   (SEL),
        .Z     (Z),
        .ZV    (ZV)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pushed = 0;
    int n_popped = 0;
    exp_t sb[$];

    // Reference model: hist[0] is the newest captured sample; fill counts genuine ones.
    logic [7:0] hist[$];
    int         fill;

    function automatic void model_clear();
        hist.delete();
        for (int k = 0; k < int'(DEPTH); k++) hist.push_back(RV);
        fill = 0;
    endfunction

    function automatic void model_shift(input logic [7:0] d);
        hist.push_front(d);
        void'(hist.pop_back());
        if (fill < int'(DEPTH)) fill++;
    endfunction

    function automatic exp_t model_expect(input string tag, input logic [7:0] d,
                                          input logic [SELW-1:0] s_in);
        exp_t e;
        int s = (int'(s_in) > int'(DEPTH)) ? int'(DEPTH) : int'(s_in);
        e.tag = tag;
        if (s == 0) begin
            e.z  = d;
            e.zv = 1'b1;
        end else begin
            e.z  = hist[s-1];
            e.zv = (fill >= s);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // One clock period: drive inputs just after the rising edge, optionally pulse RST
    // mid-cycle, publish the expectation, then let the next edge update the model.
    task automatic cycle(input bit en, input bit flush, input bit rst,
                         input logic [7:0] d, input logic [SELW-1:0] s, input string tag);
        EN = en; FLUSH = flush; I = d; SEL = s;
        if (rst) begin
            #2;
            RST = 1'b1;
            model_clear();
        end
        sb.push_back(model_expect(tag, d, s));
        n_pushed++;
        @(negedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        if (flush)   model_clear();
        else if (en) model_shift(d);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_popped++;
                check({e.tag, "_z"},  32'(Z),  32'(e.z));
                check({e.tag, "_zv"}, 32'(ZV), 32'(e.zv));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : driver
        model_clear();
        @(posedge CLK);
        #1;
        cycle(0, 0, 1, 8'h00, 4'd3, "reset");
        cycle(0, 0, 1, 8'hA5, 4'd0, "bypass_in_reset");

        for (int k = 1; k <= 6; k++) cycle(1, 0, 0, 8'(k), 4'd3, "sel3_fill");

        cycle(0, 1, 0, 8'h00, 4'd4, "flush_a");
        cycle(1, 0, 0, 8'h11, 4'd4, "stall_pre");
        cycle(1, 0, 0, 8'h22, 4'd4, "stall_pre");
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 8'($urandom), 4'd4, "stall_hold");
        for (int k = 0; k < 4; k++) cycle(1, 0, 0, 8'h33 + 8'(k), 4'd4, "stall_resume");

        for (int k = 0; k < 10; k++) cycle(1, 0, 0, 8'h80 + 8'(k), 4'd5, "fill_full");
        cycle(1, 1, 0, 8'hFF, 4'd5, "flush_en");
        for (int k = 0; k < 7; k++) cycle(1, 0, 0, 8'h40 + 8'(k), 4'd5, "refill");

        for (int k = 0; k < 9; k++) cycle(1, 0, 0, 8'hC0 + 8'(k), 4'd6, "full_pre_rst");
        cycle(0, 0, 1, 8'h00, 4'd6, "rst_pulse");
        for (int k = 0; k < 8; k++) cycle(1, 0, 0, 8'hD0 + 8'(k), 4'd6, "after_rst");

        for (int k = 0; k < 9; k++) cycle(1, 0, 0, 8'hE0 + 8'(k), 4'd15, "sel15");
        cycle(0, 0, 0, 8'h00, 4'd8, "sel8");
        cycle(0, 0, 0, 8'h00, 4'd2, "sel8to2");
        cycle(0, 0, 0, 8'h00, 4'd9, "sel9");

        for (int n = 0; n < 2000; n++) begin
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 99) == 0, 8'($urandom),
                  SELW'($urandom_range(0, 15)), "random");
        end

        @(negedge CLK);
        #1;
        check("scoreboard_drained", 32'(n_popped), 32'(n_pushed));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
